// File: rtl/pulse_meas_sched.sv
// Round-robin owner of a shared 4-bit pulse counter: gates one requester's
// event line onto the counter for WINDOW cycles and reports the count delta.
module pulse_meas_sched #(
    parameter int WINDOW = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] ev,
    input  logic [3:0] cnt_val,
    output logic       cnt_pulse,
    output logic [3:0] grant,
    output logic       busy,
    output logic       done,
    output logic [1:0] done_id,
    output logic [3:0] result
);
    // state | meaning
    // IDLE  | waiting for a request; round-robin pick from ptr
    // SNAP  | capture counter start value, load gate timer
    // GATE  | route ev[sel] onto the counter for WINDOW cycles
    // CAP   | latch counter delta and owner id
    // DONE  | one-cycle result strobe, advance ptr
    typedef enum logic [2:0] {IDLE, SNAP, GATE, CAP, DONE} state_t;

    localparam logic [3:0] GATE_LOAD = 4'(WINDOW - 1);

    state_t     state, state_nxt;
    logic [1:0] ptr, sel, pick, idx;
    logic [3:0] start, gcnt;
    logic       found;

    // Walk offsets high to low so the lowest offset from ptr wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = SNAP;
            SNAP:    state_nxt = GATE;
            GATE:    if (gcnt == 4'd0) state_nxt = CAP;
            CAP:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            sel     <= '0;
            start   <= '0;
            gcnt    <= '0;
            result  <= '0;
            done_id <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (found) sel <= pick;
                SNAP: begin
                    start <= cnt_val;
                    gcnt  <= GATE_LOAD;
                end
                GATE: if (gcnt != 4'd0) gcnt <= gcnt - 4'd1;
                CAP: begin
                    result  <= cnt_val - start;
                    done_id <= sel;
                end
                DONE: ptr <= sel + 2'd1;
                default: ;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        cnt_pulse = (state == GATE) && ev[sel];
        grant     = busy ? (4'b0001 << sel) : 4'b0000;
    end
endmodule

// File: tb/tb_pulse_meas_sched.sv
// Bench for pulse_meas_sched: models the shared counter, drives table vectors
// and an abort sequence, and scoreboards each result strobe.
module tb_pulse_meas_sched;
    localparam int WINDOW = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, ev, cnt_val, grant, result;
    logic       cnt_pulse, busy, done;
    logic [1:0] done_id;

    pulse_meas_sched #(.WINDOW(WINDOW)) dut (
        .clk(clk), .rst(rst), .req(req), .ev(ev), .cnt_val(cnt_val),
        .cnt_pulse(cnt_pulse), .grant(grant), .busy(busy), .done(done),
        .done_id(done_id), .result(result)
    );

    always #5 clk = ~clk;

    // Shared pulse counter the scheduler sits in front of.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_val <= '0;
        else if (cnt_pulse) cnt_val <= cnt_val + 4'd1;
    end

    typedef struct {
        logic [3:0] req;
        logic [3:0] ev;
        logic [3:0] tog;
        logic [3:0] exp_grant;
        logic [3:0] exp_res;
        logic [1:0] exp_id;
        bit         hold;
        bit         chk_sp;
    } vec_t;

    typedef struct {
        logic [3:0] res;
        logic [1:0] id;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_grant_cyc = 0;
    exp_t sbq[$];
    exp_t mon_e;
    vec_t vecs[11];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("result", int'(result), int'(mon_e.res));
                chk("done_id", int'(done_id), int'(mon_e.id));
            end
        end
    end

    // Called at posedge+1 in an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
    task automatic do_meas(input vec_t v, input string tag);
        exp_t e;
        int   wait_n;
        int   pc;
        e.res = v.exp_res;
        e.id  = v.exp_id;
        sbq.push_back(e);
        req = v.req;
        ev  = v.ev;
        wait_n = 0;
        do begin
            @(posedge clk); #1;
            wait_n++;
        end while (!busy && wait_n < 40);
        if (!busy) begin
            chk({tag, "_grant_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_grant"}, int'(grant), int'(v.exp_grant));
        chk({tag, "_snap_pulse"}, int'(cnt_pulse), 0);
        if (v.chk_sp) chk({tag, "_spacing"}, cyc - last_grant_cyc, WINDOW + 4);
        last_grant_cyc = cyc;
        if (!v.hold) req = 4'b0000;
        pc = 0;
        for (int k = 1; k <= WINDOW; k++) begin
            @(posedge clk); #1;
            ev = (k % 2 == 0) ? (v.ev ^ v.tog) : v.ev;
            #1;
            if (cnt_pulse) pc++;
        end
        @(posedge clk); #1;
        chk({tag, "_cap_pulse"}, int'(cnt_pulse), 0);
        chk({tag, "_pulse_cycles"}, pc, int'(v.exp_res));
        ev = 4'b0000;
        @(posedge clk); #1;
        chk({tag, "_done"}, int'(done), 1);
        @(posedge clk); #1;
        chk({tag, "_idle_busy"}, int'(busy), 0);
        chk({tag, "_idle_grant"}, int'(grant), 0);
    endtask

    initial begin
        int   wait_n;
        vec_t v;
        //          req      ev       tog      grant    res    id    hold sp
        vecs[0]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'd8, 2'd0, 0, 0};
        vecs[1]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'd8, 2'd0, 0, 0};
        vecs[2]  = '{4'b0010, 4'b0001, 4'b0000, 4'b0010, 4'd0, 2'd1, 0, 0};
        vecs[3]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'd4, 2'd2, 0, 0};
        vecs[4]  = '{4'b1000, 4'b1111, 4'b0000, 4'b1000, 4'd8, 2'd3, 0, 0};
        // counter sits at 12 here, so the next window wraps 12 -> 4
        vecs[5]  = '{4'b1111, 4'b1111, 4'b0000, 4'b0001, 4'd8, 2'd0, 1, 0};
        vecs[6]  = '{4'b1111, 4'b1111, 4'b0000, 4'b0010, 4'd8, 2'd1, 1, 1};
        vecs[7]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0100, 4'd0, 2'd2, 1, 1};
        vecs[8]  = '{4'b1111, 4'b1000, 4'b1000, 4'b1000, 4'd4, 2'd3, 1, 1};
        vecs[9]  = '{4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'd8, 2'd0, 1, 1};
        vecs[10] = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'd0, 2'd0, 0, 0};

        rst = 1'b1; req = 4'b0000; ev = 4'b0000;
        #3;
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pulse", int'(cnt_pulse), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_done_id", int'(done_id), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) do_meas(vecs[i], $sformatf("v%0d", i));

        // Abort: reset in the 3rd GATE cycle, then ptr must be back at 0.
        req = 4'b0100; ev = 4'b0100;
        wait_n = 0;
        do begin
            @(posedge clk); #1;
            wait_n++;
        end while (!busy && wait_n < 40);
        chk("abort_grant", int'(grant), 4);
        req = 4'b0000;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_pre_pulse", int'(cnt_pulse), 1);
        rst = 1'b1;
        #1;
        chk("abort_grant_clr", int'(grant), 0);
        chk("abort_busy_clr", int'(busy), 0);
        chk("abort_pulse_clr", int'(cnt_pulse), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'(result), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ev = 4'b0000;
        v = vecs[10];
        do_meas(v, "post_abort");

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
